// File: rtl/wb_block_reader_if.sv
// ---------------------------------------------------------------------------
// wb_block_reader_if
// Wishbone classic bus bundle between the block reader (master) and the
// on-chip RAM/GPIO slave.
//   wb_cyc_o, wb_stb_o : bus request, driven equal by the master
//   wb_we_o            : write enable (the reader only reads, so always 0)
//   wb_sel_o           : byte lane select (full word)
//   wb_addr_o          : word-aligned byte address
//   wb_data_i          : read data, valid while wb_ack_i is high
//   wb_ack_i           : slave acknowledge
// ---------------------------------------------------------------------------
interface wb_block_reader_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o,
        input  wb_data_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o,
        output wb_data_i, wb_ack_i
    );
endinterface

// File: rtl/wb_block_reader.sv
// ---------------------------------------------------------------------------
// wb_block_reader
// Wishbone classic master that reads a contiguous block of 32-bit words, one
// single-beat read per word, and hands each word to a valid/ready stream.
// The request is dropped between words because the slave only acknowledges
// on a rising edge of stb & cyc.
//
// Parameters
//   TIMEOUT     : cycles in REQ without an ack before the transfer aborts
//                 (4..255)
// Ports
//   clk_i, rst_i: clock, synchronous active-high reset
//   wb          : Wishbone master side of wb_block_reader_if
//   start       : one-cycle command strobe, only honoured when idle
//   base_addr   : byte address of the first word (bits [1:0] ignored)
//   word_count  : number of words to read (0 allowed)
//   busy        : high whenever a command is in progress
//   done        : one-cycle pulse at the end of every accepted command
//   err         : sticky timeout flag, cleared by the next accepted command
//   out_valid, out_data, out_ready : output word stream
// ---------------------------------------------------------------------------
module wb_block_reader #(
    parameter int TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_block_reader_if.master   wb,
    input  logic                start,
    input  logic [31:0]         base_addr,
    input  logic [15:0]         word_count,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                out_valid,
    output logic [31:0]         out_data,
    input  logic                out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_OUT,
        S_DONE
    } state_t;

    // Abort fires on the edge that ends the TIMEOUT-th REQ cycle; the counter
    // starts at 0 on REQ entry, so that is when it holds TIMEOUT-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [15:0] rem_q;
    logic [7:0]  tmo_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        cyc_q;
    logic        valid_q;
    logic [31:0] data_q;

    logic [31:0] addr_d;
    logic [15:0] rem_d;

    // Address wraps naturally modulo 2^32.
    assign addr_d = addr_q + 32'd4;
    assign rem_d  = rem_q - 16'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q <= base_addr & 32'hFFFF_FFFC;
                        rem_q  <= word_count;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        tmo_q  <= '0;
                        if (word_count == 16'd0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cyc_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end

                // An ack in the final counted cycle still wins over abort.
                S_REQ: begin
                    if (wb.wb_ack_i) begin
                        data_q  <= wb.wb_data_i;
                        cyc_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_OUT;
                    end else if (tmo_q == TMO_LAST) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end

                // cyc is already low here, which provides the request gap.
                S_OUT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        addr_q  <= addr_d;
                        rem_q   <= rem_d;
                        tmo_q   <= '0;
                        if (rem_q == 16'd1) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cyc_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = cyc_q;
    assign wb.wb_we_o   = 1'b0;
    assign wb.wb_sel_o  = 4'hF;
    assign wb.wb_addr_o = addr_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_wb_block_reader.sv
// ---------------------------------------------------------------------------
// tb_wb_block_reader
// Bench for wb_block_reader: a RAM slave that acknowledges in the third cycle
// of each request (or never, for the timeout case), and a reference model
// that derives the expected address list, word stream, cycle counts and
// flags for each command directly from its parameters.
// ---------------------------------------------------------------------------
module tb_wb_block_reader;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy, done, err, out_valid, out_ready;
    logic [31:0] out_data;

    wb_block_reader_if bus();

    wb_block_reader #(.TIMEOUT(TMO)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb         (bus.master),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // RAM slave: 1024 words, ack in the third consecutive cycle of a request.
    logic [31:0] mem [0:1023];
    logic        ack_en;
    int unsigned req_cnt = 0;

    always @(posedge clk) begin
        if (bus.wb_cyc_o && bus.wb_stb_o) req_cnt <= req_cnt + 1;
        else                               req_cnt <= 0;
    end

    assign bus.wb_ack_i  = ack_en && bus.wb_cyc_o && bus.wb_stb_o && (req_cnt == 2);
    assign bus.wb_data_i = bus.wb_ack_i ? mem[bus.wb_addr_o[11:2]] : 32'hDEAD_BEEF;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // mode 0: out_ready always high; 1: random out_ready; 2: 5-cycle stall on word 2
    task automatic run_cmd(input logic [31:0] base, input int n, input int mode, input logic acks);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] got_addr[$];
        logic [31:0] got_data[$];
        int          runs[$];
        logic [31:0] a;
        logic [31:0] prev_data;
        logic        prev_cyc, prev_valid, prev_hs, hs, err_at_done;
        int          run, k, done_k, busy_n, done_n, stall, overlap, unstable, bad_bus, exp_cycles;

        exp_addr.delete(); exp_data.delete();
        got_addr.delete(); got_data.delete(); runs.delete();
        run = 0; k = 0; done_k = 0; busy_n = 0; done_n = 0; stall = 0;
        overlap = 0; unstable = 0; bad_bus = 0; err_at_done = 1'b0;
        prev_cyc = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; prev_data = '0;

        // Reference model: word i lives at the aligned base plus 4*i, mod 2^32.
        if (n > 0) begin
            if (acks) begin
                for (int i = 0; i < n; i++) begin
                    a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
                    exp_addr.push_back(a);
                    exp_data.push_back(mem[a[11:2]]);
                end
            end else begin
                exp_addr.push_back(base & 32'hFFFF_FFFC);
            end
        end
        if (n == 0)                    exp_cycles = 1;
        else if (!acks)                exp_cycles = TMO + 1;
        else if (mode == 2 && n >= 2)  exp_cycles = 4 * n + 1 + 5;
        else                           exp_cycles = 4 * n + 1;

        ack_en = acks;
        @(negedge clk);
        base_addr  = base;
        word_count = 16'(n);
        start      = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);

        while (done_k == 0 && k < 3000) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (k == 1) begin
                check("err_clear_on_start", 32'(err), 32'd0);
                check("req_latency", 32'(bus.wb_cyc_o), 32'(n > 0));
            end
            if (busy) busy_n++;
            if ((bus.wb_cyc_o !== bus.wb_stb_o) || (bus.wb_we_o !== 1'b0) ||
                (bus.wb_sel_o !== 4'hF) || (bus.wb_addr_o[1:0] !== 2'b00))
                bad_bus++;
            if (bus.wb_cyc_o) begin
                run++;
                if (!prev_cyc) got_addr.push_back(bus.wb_addr_o);
                if (out_valid) overlap++;
            end else if (prev_cyc) begin
                runs.push_back(run);
                run = 0;
            end
            if (out_valid && prev_valid && !prev_hs && (out_data !== prev_data)) unstable++;
            if (done) begin
                done_n++;
                done_k = k;
                err_at_done = err;
            end
            if (mode == 2 && got_data.size() == 1 && out_valid && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            hs = out_valid && out_ready;
            if (hs) got_data.push_back(out_data);
            prev_cyc   = bus.wb_cyc_o;
            prev_valid = out_valid;
            prev_hs    = hs;
            prev_data  = out_data;
        end

        if (done_k == 0) check("done_seen_within_budget", 32'd0, 32'd1);

        @(negedge clk);
        out_ready = 1'b1;
        check("busy_low_after_done", 32'(busy), 32'd0);
        check("done_single_pulse", 32'(done), 32'd0);

        check("addr_count", 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            check($sformatf("addr[%0d]", i), got_addr[i], exp_addr[i]);
        check("word_count_out", 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
            check($sformatf("word[%0d]", i), got_data[i], exp_data[i]);
        for (int i = 0; i < runs.size(); i++)
            check($sformatf("cyc_run[%0d]", i), 32'(runs[i]), acks ? 32'd3 : 32'(TMO));
        check("done_pulses", 32'(done_n), 32'd1);
        check("err_at_done", 32'(err_at_done), 32'(!acks && n > 0));
        check("busy_cycles", 32'(busy_n), 32'(done_k));
        if (mode != 1) check("done_cycle", 32'(done_k), 32'(exp_cycles));
        check("no_req_while_valid", 32'(overlap), 32'd0);
        check("out_data_stable", 32'(unstable), 32'd0);
        check("bus_constants", 32'(bad_bus), 32'd0);
    endtask

    // Ignored start while busy, then reset during the second word's request.
    task automatic reset_test();
        logic [31:0] addrs[$];
        logic        prev_cyc;
        int          k, done_n, cyc_n;

        addrs.delete(); prev_cyc = 1'b0; k = 0; done_n = 0; cyc_n = 0;
        ack_en = 1'b1;
        @(negedge clk);
        base_addr  = 32'h0000_0040;
        word_count = 16'd3;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);

        while (addrs.size() < 2 && k < 50) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (k == 2) begin
                base_addr  = 32'h0000_0300;
                word_count = 16'd7;
                start      = 1'b1;
            end
            if (bus.wb_cyc_o && !prev_cyc) addrs.push_back(bus.wb_addr_o);
            prev_cyc = bus.wb_cyc_o;
        end
        start = 1'b0;
        check("rst_reached_word2", 32'(addrs.size()), 32'd2);
        if (addrs.size() == 2) check("ignored_start_addr", addrs[1], 32'h0000_0044);
        check("rst_in_req", 32'(bus.wb_cyc_o), 32'd1);

        rst = 1'b1;
        @(negedge clk);
        check("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("rst_stb", 32'(bus.wb_stb_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", bus.wb_addr_o, 32'd0);
        check("rst_data", out_data, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_n++;
            if (bus.wb_cyc_o || out_valid || busy) cyc_n++;
        end
        check("rst_no_done", 32'(done_n), 32'd0);
        check("rst_stays_idle", 32'(cyc_n), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        out_ready  = 1'b1;
        ack_en     = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[10'h040] = 32'h0000_00A0;
        mem[10'h041] = 32'h0000_00A1;
        mem[10'h042] = 32'h0000_00A2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("reset_stb", 32'(bus.wb_stb_o), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_addr", bus.wb_addr_o, 32'd0);
        check("reset_data", out_data, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_cmd(32'h0000_0100, 3, 0, 1'b1);   // basic read
        run_cmd(32'h0000_0000, 0, 0, 1'b1);   // zero count
        run_cmd(32'h0000_0200, 4, 2, 1'b1);   // backpressure on word 2
        run_cmd(32'h0000_0080, 2, 0, 1'b0);   // timeout
        check("err_sticky_after_timeout", 32'(err), 32'd1);
        run_cmd(32'h0000_0084, 1, 0, 1'b1);   // next start clears err
        run_cmd(32'hFFFF_FFFE, 2, 0, 1'b1);   // wrap and alignment
        reset_test();
        run_cmd(32'h0000_0101, 2, 0, 1'b1);   // operation after reset

        for (int t = 0; t < 8; t++)
            run_cmd($urandom, $urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom_range(0, 5) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
